// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller slice.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int unsigned LAT_MAX = 15;

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_sram_1p.sv
// Single-port synchronous word store with registered read; contents are not reset.
module sram_1p #(
   parameter int unsigned NBITS = 32,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IW    = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IW-1:0]    idx,
   input  logic [NBITS-1:0] wdata,
   output logic [NBITS-1:0] rdata
);

   logic [NBITS-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[idx] <= wdata;
      end
      rdata <= r_mem[idx];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request latch, fixed-latency FSM, address decode and error flagging
// in front of a word-addressed store.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned NBITS   = 32,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             proc_req,
   input  logic [NBITS-1:0] addr,
   input  logic             wen,
   input  logic [NBITS-1:0] wdata,
   output logic             mem_rdy,
   output logic             valid,
   output logic [NBITS-1:0] rdata,
   output logic             err
);

   localparam int unsigned IW       = idx_width(DEPTH);
   localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   generate
      if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_latency
         $error("dmem_ctrl: LATENCY must be within 1..15");
      end
   endgenerate

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_next;
   logic [NBITS-1:0] r_addr;
   logic [NBITS-1:0] r_wdata;
   logic             r_wen;
   logic [NBITS-1:0] r_rdata;
   logic [NBITS-1:0] w_sram_rdata;
   logic [IW-1:0]    w_idx;
   logic             w_accept;
   logic             w_bad;
   logic             w_we;
   logic             w_rsp_rd;

   assign mem_rdy  = (r_state == IDLE);
   assign w_accept = proc_req && mem_rdy;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_next = RESP;
               end else begin
                  w_next     = WAIT;
                  w_cnt_next = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next = RESP;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wen   <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= addr;
         r_wdata <= wdata;
         r_wen   <= wen;
      end
   end

   assign w_bad = (r_addr[1:0] != 2'b00) || ((r_addr >> (IW + 2)) != '0);

   // Index comes straight from the port while idle so that LATENCY=1 reads land on the accept edge.
   assign w_idx = (r_state == IDLE) ? addr[IW+1:2] : r_addr[IW+1:2];
   assign w_we  = (r_state == RESP) && r_wen && !w_bad;

   sram_1p #(
      .NBITS(NBITS),
      .DEPTH(DEPTH),
      .IW   (IW)
   ) u_sram (
      .clk  (clk),
      .we   (w_we),
      .idx  (w_idx),
      .wdata(r_wdata),
      .rdata(w_sram_rdata)
   );

   // The store's output register supplies the fresh word in RESP; r_rdata keeps it afterwards.
   assign w_rsp_rd = (r_state == RESP) && !r_wen;
   assign rdata    = w_rsp_rd ? (w_bad ? '0 : w_sram_rdata) : r_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_rsp_rd) begin
         r_rdata <= rdata;
      end
   end

   assign valid = (r_state == RESP);
   assign err   = valid && w_bad;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl at LATENCY 2, 1 and 15: directed checks plus random traffic against a
// transaction-level model (response due LATENCY cycles after acceptance, write commits after it).
module tb_dmem_ctrl;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pick_addr();
      int unsigned r;
      logic [31:0] base;
      r    = $urandom_range(0, 9);
      base = 32'($urandom_range(0, 15)) << 2;
      if (r < 7)       return base;
      else if (r == 7) return base | 32'($urandom_range(1, 3));
      else if (r == 8) return (32'($urandom_range(1, 255)) << 12) | base;
      else             return $urandom;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_lat
      localparam int unsigned LAT   = (g == 0) ? 2 : (g == 1) ? 1 : 15;
      localparam int unsigned DEPTH = 1024;

      logic        rst = 1'b1;
      logic        proc_req;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic        mem_rdy;
      logic        valid;
      logic [31:0] rdata;
      logic        err;
      bit          fin = 1'b0;

      dmem_ctrl #(
         .NBITS  (32),
         .DEPTH  (DEPTH),
         .LATENCY(LAT)
      ) dut (
         .clk     (clk),
         .rst     (rst),
         .proc_req(proc_req),
         .addr    (addr),
         .wen     (wen),
         .wdata   (wdata),
         .mem_rdy (mem_rdy),
         .valid   (valid),
         .rdata   (rdata),
         .err     (err)
      );

      // Transaction-level reference model, evaluated at each falling edge.
      int unsigned cyc  = 0;
      bit          pend = 1'b0;
      int unsigned due;
      logic [31:0] p_addr;
      logic [31:0] p_wdata;
      bit          p_wen;
      logic [31:0] last;
      bit          last_known = 1'b0;
      logic [31:0] mm [int unsigned];

      always @(negedge clk) begin
         bit          e_rdy;
         bit          e_val;
         bit          e_err;
         bit          bad;
         bit          k;
         logic [31:0] e_rd;
         if (rst) begin
            pend       = 1'b0;
            last       = '0;
            last_known = 1'b1;
         end
         e_rdy = !pend;
         e_val = pend && (cyc == due);
         bad   = 1'b0;
         e_err = 1'b0;
         e_rd  = last;
         k     = last_known;
         if (e_val) begin
            bad   = (p_addr % 4 != 0) || (p_addr >= DEPTH * 4);
            e_err = bad;
            if (!p_wen) begin
               if (bad) begin
                  e_rd = '0;
                  k    = 1'b1;
               end else if (mm.exists(p_addr / 4)) begin
                  e_rd = mm[p_addr / 4];
                  k    = 1'b1;
               end else begin
                  k = 1'b0;
               end
            end
         end
         chk($sformatf("L%0d model mem_rdy c%0d", LAT, cyc), 32'(mem_rdy), 32'(e_rdy));
         chk($sformatf("L%0d model valid c%0d", LAT, cyc), 32'(valid), 32'(e_val));
         chk($sformatf("L%0d model err c%0d", LAT, cyc), 32'(err), 32'(e_err));
         if (k) chk($sformatf("L%0d model rdata c%0d", LAT, cyc), rdata, e_rd);
         if (e_val) begin
            if (p_wen && !bad) mm[p_addr / 4] = p_wdata;
            if (!p_wen) begin
               last       = e_rd;
               last_known = k;
            end
            pend = 1'b0;
         end
         if (!rst && e_rdy && proc_req) begin
            pend    = 1'b1;
            due     = cyc + LAT;
            p_addr  = addr;
            p_wdata = wdata;
            p_wen   = wen;
         end
         cyc++;
      end

      task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int unsigned lat);
         bit          acc;
         int unsigned rdy_hi;
         acc    = 1'b0;
         rdy_hi = 0;
         lat    = 0;
         rd     = '0;
         er     = 1'b0;
         @(posedge clk);
         #1;
         proc_req = 1'b1;
         addr     = a;
         wen      = w;
         wdata    = d;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_rdy) begin
               acc = 1'b1;
               break;
            end
         end
         chk($sformatf("L%0d accepted 0x%08h", LAT, a), 32'(acc), 32'd1);
         @(posedge clk);
         #1;
         proc_req = 1'b0;
         addr     = $urandom;
         wen      = ~w;
         wdata    = $urandom;
         if (acc) begin
            for (int n = 1; n <= 40; n++) begin
               @(negedge clk);
               if (mem_rdy) rdy_hi++;
               if (valid) begin
                  lat = n;
                  rd  = rdata;
                  er  = err;
                  break;
               end
            end
            chk($sformatf("L%0d mem_rdy low in txn", LAT), rdy_hi, 32'd0);
         end
      endtask

      initial begin : stim
         logic [31:0] rd;
         logic        er;
         int unsigned lat;
         int unsigned cnt;
         proc_req = 1'b0;
         addr     = '0;
         wen      = 1'b0;
         wdata    = '0;
         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         #1;
         chk($sformatf("L%0d idle mem_rdy", LAT), 32'(mem_rdy), 32'd1);
         chk($sformatf("L%0d idle valid", LAT), 32'(valid), 32'd0);
         chk($sformatf("L%0d idle err", LAT), 32'(err), 32'd0);
         chk($sformatf("L%0d idle rdata", LAT), rdata, 32'd0);

         txn(32'h10, 1'b1, 32'hDEADBEEF, rd, er, lat);
         chk($sformatf("L%0d wr 0x10 latency", LAT), lat, LAT);
         chk($sformatf("L%0d wr 0x10 err", LAT), 32'(er), 32'd0);
         txn(32'h10, 1'b0, 32'h0, rd, er, lat);
         chk($sformatf("L%0d rd 0x10 latency", LAT), lat, LAT);
         chk($sformatf("L%0d rd 0x10 rdata", LAT), rd, 32'hDEADBEEF);
         chk($sformatf("L%0d rd 0x10 err", LAT), 32'(er), 32'd0);

         txn(32'h13, 1'b0, 32'h0, rd, er, lat);
         chk($sformatf("L%0d rd 0x13 err", LAT), 32'(er), 32'd1);
         chk($sformatf("L%0d rd 0x13 rdata", LAT), rd, 32'd0);

         txn(32'h0, 1'b1, 32'h0BADF00D, rd, er, lat);
         chk($sformatf("L%0d wr 0x0 err", LAT), 32'(er), 32'd0);
         txn(32'h1000, 1'b1, 32'hFFFFFFFF, rd, er, lat);
         chk($sformatf("L%0d wr 0x1000 err", LAT), 32'(er), 32'd1);
         txn(32'h0, 1'b0, 32'h0, rd, er, lat);
         chk($sformatf("L%0d rd 0x0 rdata", LAT), rd, 32'h0BADF00D);
         chk($sformatf("L%0d rd 0x0 err", LAT), 32'(er), 32'd0);

         txn(32'h20, 1'b1, 32'hA5A50020, rd, er, lat);
         @(posedge clk);
         #1;
         proc_req = 1'b1;
         addr     = 32'h20;
         wen      = 1'b1;
         wdata    = 32'h12345678;
         @(negedge clk);
         chk($sformatf("L%0d midop accept rdy", LAT), 32'(mem_rdy), 32'd1);
         @(posedge clk);
         #1;
         proc_req = 1'b0;
         rst      = 1'b1;
         #1;
         chk($sformatf("L%0d async rst mem_rdy", LAT), 32'(mem_rdy), 32'd1);
         chk($sformatf("L%0d async rst valid", LAT), 32'(valid), 32'd0);
         chk($sformatf("L%0d async rst err", LAT), 32'(err), 32'd0);
         chk($sformatf("L%0d async rst rdata", LAT), rdata, 32'd0);
         @(posedge clk);
         #1 rst = 1'b0;
         cnt = 0;
         repeat (LAT + 3) begin
            @(negedge clk);
            if (valid) cnt++;
         end
         chk($sformatf("L%0d no valid after rst", LAT), cnt, 32'd0);
         txn(32'h20, 1'b0, 32'h0, rd, er, lat);
         chk($sformatf("L%0d rd 0x20 after rst", LAT), rd, 32'hA5A50020);

         @(posedge clk);
         #1;
         proc_req = 1'b1;
         addr     = 32'h10;
         wen      = 1'b0;
         cnt      = 0;
         for (int i = 0; i < 4 * (LAT + 1); i++) begin
            @(negedge clk);
            chk($sformatf("L%0d thr mem_rdy c%0d", LAT, i), 32'(mem_rdy),
                32'((i % (LAT + 1)) == 0));
            if (mem_rdy) cnt++;
         end
         @(posedge clk);
         #1 proc_req = 1'b0;
         chk($sformatf("L%0d thr acceptances", LAT), cnt, 32'd4);

         for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 199) == 0);
            proc_req = ($urandom_range(0, 3) != 0);
            wen      = 1'($urandom_range(0, 1));
            addr     = pick_addr();
            wdata    = $urandom;
         end
         @(posedge clk);
         #1;
         rst      = 1'b0;
         proc_req = 1'b0;
         repeat (LAT + 3) @(posedge clk);
         fin = 1'b1;
      end
   end

   initial begin
      wait (g_lat[0].fin && g_lat[1].fin && g_lat[2].fin);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion (%0d vectors so far)", vectors);
      $fatal(1, "bench did not complete");
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller and storage that sits directly downstream of the core's data port.
- Consumes dproc_req / daddr / op2mem / wenMem from the core.
- Returns the dmem_rdy / dvalid / ddata handshake after a fixed, parameterised access latency.
- Holds a word-addressed backing store; flags misaligned and out-of-range accesses.

Parameters:
NBITS, 32, data and address width
DEPTH, 1024, number of NBITS-wide words in the store (power of two)
LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
proc_req  input  1  core requests an access; held with operands until accepted
addr  input  NBITS  byte address
wen  input  1  1 = write, 0 = read
wdata  input  NBITS  write data
mem_rdy  output  1  controller can accept a request this cycle
valid  output  1  one-cycle response strobe (read data or write ack)
rdata  output  NBITS  read data; meaningful when valid=1 and wen was 0
err  output  1  with valid: access was misaligned or out of range

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, counter=0, valid=0, err=0, rdata=0, mem_rdy=1 once state is IDLE. The storage array is not cleared.
- Acceptance occurs on a rising edge where proc_req=1 and mem_rdy=1. At that edge the controller latches addr, wen and wdata; later changes on the inputs are ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: mem_rdy=1. On acceptance, go to RESP if LATENCY=1, otherwise go to WAIT with counter=LATENCY-2.
  - WAIT: mem_rdy=0. Counter decrements each cycle; when counter=0, go to RESP.
  - RESP: mem_rdy=0, valid=1 for exactly one cycle, then go to IDLE.
- Timing: if acceptance happens at the edge ending cycle 0, valid is high in cycle LATENCY.
  - Back-to-back throughput is one transaction per LATENCY+1 cycles.
  - There is no acceptance in RESP.
- Address decode: word index = addr[log2(DEPTH)+1:2].
  - bad = (addr[1:0] != 0) OR (addr[NBITS-1:log2(DEPTH)+2] != 0).
  - bad is evaluated on the latched address.
- Read:
  - rdata is registered: it is loaded with store[index] on the edge entering RESP, and holds until the next response.
  - If bad: rdata=0, err=1.
- Write:
  - The store is updated with the latched wdata at the edge ending RESP.
  - If bad: no write and err=1. rdata is unchanged for writes.
- err is valid only with valid and is 0 otherwise.
- A read issued immediately after a write to the same word returns the new data, because the write commits before the next acceptance.
- proc_req dropped while not accepted has no effect. proc_req high in WAIT/RESP is ignored, and is accepted in the next IDLE if still high.
- Reset mid-operation (WAIT or RESP): the transaction is discarded, no write occurs, valid=0 immediately, and the FSM returns to IDLE.
- Counter width is 4 bits. LATENCY outside 1..15 is a static elaboration error.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - LAT_MAX=15
  - localparam function for the index width (clog2 of DEPTH)
- One sub-module sram_1p: single-port synchronous array with clk, we, idx, wdata, rdata (registered read), no reset.
- dmem_ctrl holds the FSM, counter, request latch, decode and error logic.

Test Plan:
- Reset: assert rst mid-cycle -> mem_rdy=1, valid=0, err=0, rdata=0 immediately (asynchronous); deassert -> still idle.
- Write then read, LATENCY=2:
  - write 0xDEADBEEF to addr 0x10 -> valid in cycle 2 after accept, err=0.
  - read 0x10 -> valid 2 cycles after accept with rdata=0xDEADBEEF.
- Errors:
  - read addr 0x13 (misaligned) -> valid with err=1, rdata=0.
  - write 0x0000_1000 with DEPTH=1024 (out of range) -> err=1; a subsequent read of 0x0 is unaffected.
- Throughput: proc_req held high for 12 cycles with LATENCY=2 -> exactly 4 acceptances; mem_rdy pattern 1,0,0 repeating.
- Reset mid-op: accept a write of 0x12345678 to 0x20, assert rst during WAIT -> no valid pulse; a later read of 0x20 returns the prior contents.
- Latency sweep: LATENCY=1 -> valid in cycle 1; LATENCY=15 -> valid in cycle 15; mem_rdy=0 throughout each transaction.
